// File: rtl/fft8_twiddle_sched.sv
// Index/twiddle sequencer for the shared complex multiplier of an 8-point radix-2 DIT FFT.
// Optional macro FFT8_STAGE_BARRIER_EN adds wb_done and a per-stage writeback barrier.
module fft8_twiddle_sched #(
    parameter int W_WIDTH   = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
`ifdef FFT8_STAGE_BARRIER_EN
    input  logic                      wb_done,
`endif
    output logic                      busy,
    output logic                      done,
    output logic                      op_valid,
    input  logic                      op_ready,
    output logic [1:0]                op_stage,
    output logic [2:0]                op_top,
    output logic [2:0]                op_bot,
    output logic [1:0]                op_tw_idx,
    output logic signed [W_WIDTH-1:0] W_real,
    output logic signed [W_WIDTH-1:0] W_imag,
    output logic [1:0]                state_dbg
);

    // Handshake: an op transfers on a rising edge where op_valid & op_ready; until
    // then every op_* and W_* field holds, and op_valid only falls on transfer or reset.

`ifdef FFT8_STAGE_BARRIER_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_DONE    = 2'd2,
        S_WAIT_WB = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    localparam int ONE        = 1 << FRAC_BITS;
    localparam int HALF_SQRT2 = int'(0.7071067811865476 * real'(ONE));

    state_t state;
    state_t state_next;

    logic [1:0] s;
    logic [1:0] b;
    logic [1:0] s_next;
    logic [1:0] b_next;
    logic       load;
    logic       op_valid_next;
    logic       busy_next;
    logic       done_next;
    logic       accept;

    logic [2:0] h3;
    logic [2:0] pos3;
    logic [2:0] grp3;
    logic [2:0] top3;
    logic [2:0] bot3;
    logic [1:0] k2;
    logic signed [W_WIDTH-1:0] tw_re;
    logic signed [W_WIDTH-1:0] tw_im;

`ifdef FFT8_STAGE_BARRIER_EN
    logic [2:0] wb_cnt;
    logic [2:0] wb_cnt_next;
    logic       wb_reached;
`endif

    assign accept    = op_valid & op_ready;
    assign state_dbg = state;

`ifdef FFT8_STAGE_BARRIER_EN
    // The pulse arriving this cycle counts toward the barrier, so release is one cycle after it.
    assign wb_reached = ({1'b0, wb_cnt} + {3'b000, wb_done}) >= 4'd4;
`endif

    always_comb begin
        state_next    = state;
        s_next        = s;
        b_next        = b;
        load          = 1'b0;
        op_valid_next = op_valid;
        busy_next     = busy;
        done_next     = 1'b0;
`ifdef FFT8_STAGE_BARRIER_EN
        wb_cnt_next   = wb_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_ISSUE;
                    s_next        = 2'd0;
                    b_next        = 2'd0;
                    load          = 1'b1;
                    op_valid_next = 1'b1;
                    busy_next     = 1'b1;
`ifdef FFT8_STAGE_BARRIER_EN
                    wb_cnt_next   = 3'd0;
`endif
                end
            end
            S_ISSUE: begin
`ifdef FFT8_STAGE_BARRIER_EN
                if (wb_done && wb_cnt != 3'd7) begin
                    wb_cnt_next = wb_cnt + 3'd1;
                end
`endif
                if (accept) begin
                    if (b == 2'd3) begin
                        if (s == 2'd2) begin
                            state_next    = S_DONE;
                            op_valid_next = 1'b0;
                            busy_next     = 1'b0;
                            done_next     = 1'b1;
                        end else begin
                            s_next = s + 2'd1;
                            b_next = 2'd0;
`ifdef FFT8_STAGE_BARRIER_EN
                            state_next    = S_WAIT_WB;
                            op_valid_next = 1'b0;
`else
                            load          = 1'b1;
`endif
                        end
                    end else begin
                        b_next = b + 2'd1;
                        load   = 1'b1;
                    end
                end
            end
`ifdef FFT8_STAGE_BARRIER_EN
            S_WAIT_WB: begin
                if (wb_reached) begin
                    state_next    = S_ISSUE;
                    load          = 1'b1;
                    op_valid_next = 1'b1;
                    wb_cnt_next   = 3'd0;
                end else if (wb_done && wb_cnt != 3'd7) begin
                    wb_cnt_next = wb_cnt + 3'd1;
                end
            end
`endif
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Butterfly geometry for the op about to be loaded: h = 1<<s, pos = b&(h-1), grp = b>>s.
    always_comb begin
        h3   = 3'b001 << s_next;
        pos3 = {1'b0, b_next} & (h3 - 3'd1);
        grp3 = {1'b0, b_next} >> s_next;
        top3 = (grp3 << (s_next + 2'd1)) + pos3;
        bot3 = top3 + h3;
        k2   = pos3[1:0] << (2'd2 - s_next);
    end

    // W8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8), scaled by 2^FRAC_BITS.
    always_comb begin
        tw_re = '0;
        tw_im = '0;
        case (k2)
            2'd0: begin
                tw_re = W_WIDTH'(ONE);
                tw_im = '0;
            end
            2'd1: begin
                tw_re = W_WIDTH'(HALF_SQRT2);
                tw_im = W_WIDTH'(-HALF_SQRT2);
            end
            2'd2: begin
                tw_re = '0;
                tw_im = W_WIDTH'(-ONE);
            end
            default: begin
                tw_re = W_WIDTH'(-HALF_SQRT2);
                tw_im = W_WIDTH'(-HALF_SQRT2);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            s         <= 2'd0;
            b         <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            op_valid  <= 1'b0;
            op_stage  <= 2'd0;
            op_top    <= 3'd0;
            op_bot    <= 3'd0;
            op_tw_idx <= 2'd0;
            W_real    <= '0;
            W_imag    <= '0;
        end else begin
            state    <= state_next;
            s        <= s_next;
            b        <= b_next;
            busy     <= busy_next;
            done     <= done_next;
            op_valid <= op_valid_next;
            if (load) begin
                op_stage  <= s_next;
                op_top    <= top3;
                op_bot    <= bot3;
                op_tw_idx <= k2;
                W_real    <= tw_re;
                W_imag    <= tw_im;
            end
        end
    end

`ifdef FFT8_STAGE_BARRIER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_cnt <= 3'd0;
        end else begin
            wb_cnt <= wb_cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_fft8_twiddle_sched.sv
// Self-checking bench for fft8_twiddle_sched: op order, timing, stall, start filtering, reset.
`timescale 1ns/1ps
module tb_fft8_twiddle_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_ready;
    logic        busy;
    logic        done;
    logic        op_valid;
    logic [1:0]  op_stage;
    logic [2:0]  op_top;
    logic [2:0]  op_bot;
    logic [1:0]  op_tw_idx;
    logic signed [15:0] W_real;
    logic signed [15:0] W_imag;
    logic [1:0]  state_dbg;
`ifdef FFT8_STAGE_BARRIER_EN
    logic        wb_done;
`endif

    int checks = 0;
    int errors = 0;
    logic [41:0] exp_q[$];

    fft8_twiddle_sched #(.W_WIDTH(16), .FRAC_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef FFT8_STAGE_BARRIER_EN
        .wb_done   (wb_done),
`endif
        .busy      (busy),
        .done      (done),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_stage  (op_stage),
        .op_top    (op_top),
        .op_bot    (op_bot),
        .op_tw_idx (op_tw_idx),
        .W_real    (W_real),
        .W_imag    (W_imag),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference op n (0..11): {stage, top, bot, k, W_real, W_imag} from the DIT pair table.
    function automatic logic [41:0] exp_op(input int n);
        logic [2:0]  t;
        logic [2:0]  bt;
        logic [1:0]  k;
        logic [15:0] wr;
        logic [15:0] wi;
        case (n)
            0:       begin t = 3'd0; bt = 3'd1; k = 2'd0; end
            1:       begin t = 3'd2; bt = 3'd3; k = 2'd0; end
            2:       begin t = 3'd4; bt = 3'd5; k = 2'd0; end
            3:       begin t = 3'd6; bt = 3'd7; k = 2'd0; end
            4:       begin t = 3'd0; bt = 3'd2; k = 2'd0; end
            5:       begin t = 3'd1; bt = 3'd3; k = 2'd2; end
            6:       begin t = 3'd4; bt = 3'd6; k = 2'd0; end
            7:       begin t = 3'd5; bt = 3'd7; k = 2'd2; end
            8:       begin t = 3'd0; bt = 3'd4; k = 2'd0; end
            9:       begin t = 3'd1; bt = 3'd5; k = 2'd1; end
            10:      begin t = 3'd2; bt = 3'd6; k = 2'd2; end
            default: begin t = 3'd3; bt = 3'd7; k = 2'd3; end
        endcase
        case (k)
            2'd0:    begin wr = 16'h0100; wi = 16'h0000; end
            2'd1:    begin wr = 16'h00B5; wi = 16'hFF4B; end
            2'd2:    begin wr = 16'h0000; wi = 16'hFF00; end
            default: begin wr = 16'hFF4B; wi = 16'hFF4B; end
        endcase
        return {2'(n / 4), t, bt, k, wr, wi};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, op_valid, op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {busy, done, op_valid, op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag});
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d required 0", state_dbg);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b done=%b required 0 0 0", op_valid, busy, done);
        end
    endtask

    task automatic test_full_run();
        logic [41:0] got;
        logic [41:0] exp;
        int n_acc = 0;
        op_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_op(i));
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            checks++;
            if (op_valid !== (cyc <= 12) || busy !== (cyc <= 12) || done !== (cyc == 13)) begin
                errors++;
                $display("FAIL run_timing cyc=%0d: valid=%b busy=%b done=%b required %b %b %b",
                         cyc, op_valid, busy, done, cyc <= 12, cyc <= 12, cyc == 13);
            end
            if (cyc == 10) begin
                checks++;
                if (op_top !== 3'd1 || op_bot !== 3'd5 || op_tw_idx !== 2'd1 ||
                    W_real !== 16'h00B5 || W_imag !== 16'hFF4B) begin
                    errors++;
                    $display("FAIL stage2_b1: got top=%0d bot=%0d k=%0d W=(%h,%h) required 1 5 1 (00b5,ff4b)",
                             op_top, op_bot, op_tw_idx, W_real, W_imag);
                end
            end
            if (op_valid && op_ready) begin
                got = {op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL run_op_extra: got %h required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL run_op%0d: got %h required %h", n_acc, got, exp);
                    end
                end
                n_acc++;
            end
            @(negedge clk);
        end
        checks++;
        if (n_acc != 12 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL run_op_count: got %0d ops, %0d left, required 12 ops, 0 left", n_acc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic [41:0] got;
        logic [41:0] exp;
        logic [41:0] held = '0;
        int n_acc = 0;
        int stall = 0;
        int done_cyc = -1;
        op_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_op(i));
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            got = {op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag};
            if (done) done_cyc = cyc;
            if (op_valid && n_acc == 5 && stall < 3) begin
                op_ready = 1'b0;
                if (stall == 0) held = got;
                checks++;
                if (got !== held || got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d: got %h required %h", cyc, got, exp_q[0]);
                end
                stall++;
            end else begin
                op_ready = 1'b1;
            end
            if (op_valid && op_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_op_extra: got %h required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL stall_op%0d: got %h required %h", n_acc, got, exp);
                    end
                end
                n_acc++;
            end
            @(negedge clk);
        end
        op_ready = 1'b1;
        checks++;
        if (done_cyc != 16) begin
            errors++;
            $display("FAIL stall_done_cycle: got %0d required 16", done_cyc);
        end
        checks++;
        if (n_acc != 12 || exp_q.size() != 0 || stall != 3) begin
            errors++;
            $display("FAIL stall_op_count: got %0d ops %0d stalls, required 12 ops 3 stalls", n_acc, stall);
        end
        checks++;
        if (held[31:0] !== 32'h0000_FF00) begin
            errors++;
            $display("FAIL stall_twiddle: got %h required 0000ff00", held[31:0]);
        end
        exp_q.delete();
    endtask

    task automatic test_start_ignored();
        logic [41:0] got;
        logic [41:0] exp;
        int n_acc = 0;
        int n_done = 0;
        int done1 = -1;
        int done2 = -1;
        op_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_op(i));
        @(negedge clk);
        for (int cyc = 1; cyc <= 28; cyc++) begin
            start = (cyc == 5 || cyc == 13 || cyc == 14);
            if (cyc == 14) begin
                for (int i = 0; i < 12; i++) exp_q.push_back(exp_op(i));
            end
            if (done) begin
                n_done++;
                if (n_done == 1) done1 = cyc;
                else done2 = cyc;
            end
            if (cyc == 14) begin
                checks++;
                if (op_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL start_at_done: valid=%b busy=%b required 0 0", op_valid, busy);
                end
            end
            if (op_valid && op_ready) begin
                got = {op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL restart_op_extra: got %h required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL restart_op%0d: got %h required %h", n_acc, got, exp);
                    end
                end
                n_acc++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (n_done != 2 || done1 != 13 || done2 != 27) begin
            errors++;
            $display("FAIL restart_done: got %0d pulses at %0d,%0d required 2 at 13,27", n_done, done1, done2);
        end
        checks++;
        if (n_acc != 24 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_op_count: got %0d required 24", n_acc);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midrun();
        logic [41:0] got;
        logic [41:0] exp;
        int n_acc = 0;
        int n_done = 0;
        op_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_op(i));
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (op_valid && op_ready) begin
                got = {op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag};
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL pre_reset_op%0d: got %h required %h", n_acc, got, exp);
                end
                n_acc++;
            end
            @(negedge clk);
        end
        checks++;
        if (op_valid !== 1'b1 || op_stage !== 2'd1 || op_top !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset_position: valid=%b stage=%0d top=%0d required 1 1 1", op_valid, op_stage, op_top);
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({busy, done, op_valid, op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag} !== '0 ||
            state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL midrun_reset: got %h state=%0d required 0 state 0",
                     {busy, done, op_valid, op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag}, state_dbg);
        end
        reset = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (done || op_valid) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d active cycles required 0", n_done);
        end
        n_acc = 0;
        start = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_op(i));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (op_valid !== 1'b1 || op_stage !== 2'd0 || op_top !== 3'd0 || op_bot !== 3'd1) begin
            errors++;
            $display("FAIL rerun_first: valid=%b stage=%0d pair=(%0d,%0d) required 1 0 (0,1)",
                     op_valid, op_stage, op_top, op_bot);
        end
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (op_valid && op_ready) begin
                got = {op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rerun_op_extra: got %h required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL rerun_op%0d: got %h required %h", n_acc, got, exp);
                    end
                end
                n_acc++;
            end
            @(negedge clk);
        end
        checks++;
        if (n_acc != 12) begin
            errors++;
            $display("FAIL rerun_op_count: got %0d required 12", n_acc);
        end
        exp_q.delete();
    endtask

`ifdef FFT8_STAGE_BARRIER_EN
    task automatic test_barrier();
        logic [41:0] got;
        logic [41:0] exp;
        int n_acc = 0;
        int n_done = 0;
        int s0_end = -1;
        op_ready = 1'b1;
        wb_done = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_op(i));
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            wb_done = 1'b0;
            if (s0_end > 0 && cyc >= s0_end + 5 && cyc <= s0_end + 8) wb_done = 1'b1;
            if (op_valid && op_stage == 2'd1) wb_done = 1'b1;
            if (done) n_done++;
            if (s0_end > 0 && cyc > s0_end && cyc <= s0_end + 8) begin
                checks++;
                if (op_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL barrier_hold cyc=%0d: valid=%b required 0", cyc, op_valid);
                end
            end
            if (s0_end > 0 && cyc == s0_end + 9) begin
                checks++;
                if (op_valid !== 1'b1 || op_stage !== 2'd1 || op_top !== 3'd0 || op_bot !== 3'd2) begin
                    errors++;
                    $display("FAIL barrier_release: valid=%b stage=%0d pair=(%0d,%0d) required 1 1 (0,2)",
                             op_valid, op_stage, op_top, op_bot);
                end
            end
            if (op_valid && op_ready) begin
                got = {op_stage, op_top, op_bot, op_tw_idx, W_real, W_imag};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL barrier_op_extra: got %h required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL barrier_op%0d: got %h required %h", n_acc, got, exp);
                    end
                end
                n_acc++;
                if (n_acc == 4) s0_end = cyc;
            end
            @(negedge clk);
        end
        wb_done = 1'b0;
        checks++;
        if (n_acc != 12 || n_done != 1) begin
            errors++;
            $display("FAIL barrier_run: got %0d ops %0d done required 12 ops 1 done", n_acc, n_done);
        end
        exp_q.delete();
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_ready = 1'b0;
`ifdef FFT8_STAGE_BARRIER_EN
        wb_done = 1'b0;
`endif
        test_reset();
        test_full_run();
        repeat (2) @(negedge clk);
        test_stall();
        repeat (2) @(negedge clk);
        test_start_ignored();
        repeat (2) @(negedge clk);
        test_reset_midrun();
`ifdef FFT8_STAGE_BARRIER_EN
        repeat (2) @(negedge clk);
        test_barrier();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
